ram_programavel: RTL

//  Parametrised program/data RAM for the SAP-1 datapath, successor to the fixed 16x8 ROM-style RAM.

---
 rtl/sap1_pkg.sv | 21 ++
 rtl/ram_programavel_if.sv | 33 +++
 rtl/ram_programavel_carregador.sv | 76 +++++++
 rtl/ram_programavel.sv | 114 +++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcode encodings, loader state type and instruction packing.
package sap1_pkg;

    localparam logic [3:0] LDA = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;

    typedef enum logic [1:0] {
        OCIOSO,
        CARGA,
        CONCLUIDO
    } estado_carga_t;

    // Upper nibble opcode, lower nibble operand address.
    function automatic logic [7:0] instrucao(input logic [3:0] op, input logic [3:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/ram_programavel_if.sv
// Bus bundle between the SAP-1 datapath/loader host (master) and the program RAM (slave).
interface ram_programavel_if #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 4
);
    logic                    CE;
    logic                    ciclo_busca;
    logic [LARGURA_END-1:0]  endereco_pc;
    logic [LARGURA_END-1:0]  endereco_dado;
    logic                    WE;
    logic [LARGURA_DADO-1:0] dado_escrita;
    logic [LARGURA_DADO-1:0] barramento_w;
    logic                    barramento_oe;
    logic                    modo_prog;
    logic                    carga_valido;
    logic [LARGURA_DADO-1:0] carga_dado;
    logic                    carga_pronto;
    logic                    carga_fim;
    logic                    erro_conflito;

    modport master (
        output CE, ciclo_busca, endereco_pc, endereco_dado, WE, dado_escrita,
        output modo_prog, carga_valido, carga_dado,
        input  barramento_w, barramento_oe, carga_pronto, carga_fim, erro_conflito
    );

    modport slave (
        input  CE, ciclo_busca, endereco_pc, endereco_dado, WE, dado_escrita,
        input  modo_prog, carga_valido, carga_dado,
        output barramento_w, barramento_oe, carga_pronto, carga_fim, erro_conflito
    );

endinterface

// File: rtl/ram_programavel_carregador.sv
// Byte-stream loader: walks a pointer through the whole memory while modo_prog is held,
// emitting one write strobe per accepted byte.
module carregador_ram
    import sap1_pkg::*;
#(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    modo_prog,
    input  logic                    carga_valido,
    input  logic [LARGURA_DADO-1:0] carga_dado,
    output logic                    carga_pronto,
    output logic                    carga_fim,
    output logic                    escrita_en,
    output logic [LARGURA_END-1:0]  escrita_end,
    output logic [LARGURA_DADO-1:0] escrita_dado
);

    localparam logic [LARGURA_END-1:0] PTR_MAX = '1;

    estado_carga_t          estado_q, estado_d;
    logic [LARGURA_END-1:0] ptr_q, ptr_d;
    logic                   aceite;

    always_ff @(posedge clk) begin
        if (clr) begin
            estado_q <= OCIOSO;
            ptr_q    <= '0;
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        ptr_d        = ptr_q;
        carga_pronto = 1'b0;
        carga_fim    = 1'b0;
        aceite       = 1'b0;
        case (estado_q)
            OCIOSO: begin
                ptr_d = '0;
                if (modo_prog) estado_d = CARGA;
            end
            CARGA: begin
                // Ready only while the host still owns the memory, so a byte offered in the
                // cycle modo_prog drops is never half-accepted.
                carga_pronto = modo_prog;
                aceite       = carga_valido & modo_prog;
                if (!modo_prog) begin
                    estado_d = OCIOSO;
                    ptr_d    = '0;
                end else if (carga_valido) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == PTR_MAX) estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                carga_fim = 1'b1;
                if (!modo_prog) estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
                ptr_d    = '0;
            end
        endcase
    end

    assign escrita_en   = aceite;
    assign escrita_end  = ptr_q;
    assign escrita_dado = carga_dado;

endmodule

// File: rtl/ram_programavel.sv
// SAP-1 program/data RAM: registered read onto the W bus, CPU write port and byte loader
// sharing a single synchronous memory array.
module ram_programavel
    import sap1_pkg::*;
#(
    parameter int LARGURA_DADO     = 8,
    parameter int LARGURA_END      = 4,
    parameter int USAR_PROG_PADRAO = 1
) (
    input logic            clk,
    input logic            clr,
    ram_programavel_if.slave bus
);

    localparam int PROFUNDIDADE = 2 ** LARGURA_END;
    localparam bit USA_IMAGEM   = (USAR_PROG_PADRAO != 0) && (LARGURA_DADO == 8) && (LARGURA_END == 4);

    logic                    carga_we;
    logic [LARGURA_END-1:0]  carga_end;
    logic [LARGURA_DADO-1:0] carga_dado_w;

    logic                    ler;
    logic [LARGURA_END-1:0]  end_leitura;
    logic                    mem_we;
    logic [LARGURA_END-1:0]  mem_end;
    logic [LARGURA_DADO-1:0] mem_dado;

    logic [LARGURA_DADO-1:0] barramento_w_q;
    logic                    barramento_oe_q, barramento_oe_d;
    logic                    erro_conflito_q, erro_conflito_d;

    carregador_ram #(
        .LARGURA_DADO(LARGURA_DADO),
        .LARGURA_END (LARGURA_END)
    ) u_carregador (
        .clk         (clk),
        .clr         (clr),
        .modo_prog   (bus.modo_prog),
        .carga_valido(bus.carga_valido),
        .carga_dado  (bus.carga_dado),
        .carga_pronto(bus.carga_pronto),
        .carga_fim   (bus.carga_fim),
        .escrita_en  (carga_we),
        .escrita_end (carga_end),
        .escrita_dado(carga_dado_w)
    );

    always_comb begin
        ler         = !bus.modo_prog && !bus.CE;
        end_leitura = bus.ciclo_busca ? bus.endereco_pc : bus.endereco_dado;
        mem_we      = 1'b0;
        mem_end     = bus.endereco_dado;
        mem_dado    = bus.dado_escrita;
        // Loader and CPU never write together: modo_prog hands the single port to the loader.
        if (bus.modo_prog) begin
            mem_we   = carga_we && !clr;
            mem_end  = carga_end;
            mem_dado = carga_dado_w;
        end else begin
            mem_we   = bus.WE && bus.CE && !clr;
        end
        barramento_oe_d = ler;
        erro_conflito_d = erro_conflito_q || (!bus.modo_prog && bus.WE && !bus.CE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            barramento_oe_q <= 1'b0;
            erro_conflito_q <= 1'b0;
        end else begin
            barramento_oe_q <= barramento_oe_d;
            erro_conflito_q <= erro_conflito_d;
        end
    end

    // Storage is duplicated per branch only so the demo image can be attached as the
    // array's power-up contents; both branches behave identically afterwards.
    generate
        if (USA_IMAGEM) begin : g_mem
            logic [LARGURA_DADO-1:0] mem_q [PROFUNDIDADE] = '{
                0:  instrucao(LDA, 4'd10),
                1:  instrucao(ADD, 4'd11),
                2:  instrucao(ADD, 4'd12),
                3:  instrucao(SUB, 4'd13),
                4:  instrucao(OUT, 4'd0),
                5:  instrucao(HLT, 4'd0),
                10: 8'd1,
                11: 8'd4,
                12: 8'd5,
                13: 8'd6,
                default: '0
            };

            always_ff @(posedge clk) begin
                if (mem_we) mem_q[mem_end] <= mem_dado;
                if (clr) barramento_w_q <= '0;
                else if (ler) barramento_w_q <= mem_q[end_leitura];
            end
        end else begin : g_mem
            logic [LARGURA_DADO-1:0] mem_q [PROFUNDIDADE] = '{default: '0};

            always_ff @(posedge clk) begin
                if (mem_we) mem_q[mem_end] <= mem_dado;
                if (clr) barramento_w_q <= '0;
                else if (ler) barramento_w_q <= mem_q[end_leitura];
            end
        end
    endgenerate

    assign bus.barramento_w  = barramento_w_q;
    assign bus.barramento_oe = barramento_oe_q;
    assign bus.erro_conflito = erro_conflito_q;

endmodule
